// File: rtl/fccc_seq_pkg.sv
// Shared state encoding and default constants for the CCC lock-qualified
// reset/clock-enable sequencer.
package fccc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUALIFY = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_LOST    = 3'd4
   } seq_state_e;

   localparam int unsigned DEF_NUM_CH        = 4;
   localparam int unsigned DEF_DIV_W         = 8;
   localparam int unsigned DEF_LOCK_DEBOUNCE = 16;
   localparam int unsigned DEF_STAGGER       = 4;

   localparam logic [7:0]  LOST_CNT_MAX      = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == LOST_CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fccc_ce_div.sv
// One channel of the clock-enable divider: counter held at 0 in reset,
// counts 0..ratio and wraps, with a registered CE pulse on each wrap.
module fccc_ce_div
   import fccc_seq_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rst_cur,
   input  logic             rst_nxt,
   input  logic [DIV_W-1:0] ratio_in,
   output logic             ce_out
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] ratio_q, ratio_d;
   logic             ce_q, ce_d;
   logic             wrap;

   // rst_nxt lets CE drop on the same edge the channel re-enters reset
   always_comb begin
      wrap    = (cnt_q == ratio_q);
      cnt_d   = cnt_q + DIV_W'(1);
      ratio_d = ratio_q;
      ce_d    = 1'b0;
      if (rst_cur || rst_nxt) begin
         cnt_d = '0;
         if (rst_cur) begin
            ratio_d = ratio_in;
         end
      end else if (wrap) begin
         cnt_d   = '0;
         ratio_d = ratio_in;
         ce_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         ratio_q <= '0;
         ce_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         ce_q    <= ce_d;
      end
   end

   assign ce_out = ce_q;

endmodule

// File: rtl/fccc_rst_seq.sv
// Lock-qualified staggered reset release with per-channel CE dividers.
// Optional FCCC_LOCK_LOSS_CNT_EN builds the saturating lock-loss counter.
//
//   state   | meaning
//   IDLE    | all channels in reset, waiting for synchronized lock
//   QUALIFY | debouncing lock high for LOCK_DEBOUNCE cycles
//   RELEASE | deasserting channel resets one by one, STAGGER apart
//   RUN     | all channels running, READY high
//   LOST    | lock dropped; resets reasserted, return to IDLE next edge
module fccc_rst_seq
   import fccc_seq_pkg::*;
#(
   parameter int unsigned NUM_CH        = DEF_NUM_CH,
   parameter int unsigned DIV_W         = DEF_DIV_W,
   parameter int unsigned LOCK_DEBOUNCE = DEF_LOCK_DEBOUNCE,
   parameter int unsigned STAGGER       = DEF_STAGGER
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    LOCK,
   input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
   output logic [NUM_CH-1:0]       CE_OUT,
   output logic [NUM_CH-1:0]       RST_OUT,
   output logic                    READY,
   output logic [7:0]              LOCK_LOST_CNT
);

   localparam int unsigned DEB_W = (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
   localparam int unsigned STG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_CH + 1);

   logic              lock_meta_q;
   logic              lock_s_q;
   seq_state_e        state_q, state_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [STG_W-1:0]  stg_q, stg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] rst_q, rst_d;
   logic              ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      stg_d   = stg_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      unique case (state_q)
         ST_IDLE: begin
            rst_d   = '1;
            ready_d = 1'b0;
            deb_d   = '0;
            if (lock_s_q) begin
               state_d = ST_QUALIFY;
            end
         end
         ST_QUALIFY: begin
            if (!lock_s_q) begin
               state_d = ST_IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_W'(LOCK_DEBOUNCE - 1)) begin
               state_d  = ST_RELEASE;
               rst_d[0] = 1'b0;
               stg_d    = STG_W'(STAGGER - 1);
               idx_d    = IDX_W'(1);
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         ST_RELEASE: begin
            if (!lock_s_q) begin
               state_d = ST_LOST;
               rst_d   = '1;
               ready_d = 1'b0;
            end else if (idx_q == IDX_W'(NUM_CH)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else if (stg_q == '0) begin
               // idx_q names the next channel still held in reset
               for (int k = 0; k < NUM_CH; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     rst_d[k] = 1'b0;
                  end
               end
               idx_d = idx_q + IDX_W'(1);
               stg_d = STG_W'(STAGGER - 1);
            end else begin
               stg_d = stg_q - STG_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s_q) begin
               state_d = ST_LOST;
               rst_d   = '1;
               ready_d = 1'b0;
            end
         end
         ST_LOST: begin
            state_d = ST_IDLE;
            rst_d   = '1;
            ready_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            rst_d   = '1;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= ST_IDLE;
         deb_q       <= '0;
         stg_q       <= '0;
         idx_q       <= '0;
         rst_q       <= '1;
         ready_q     <= 1'b0;
      end else begin
         lock_meta_q <= LOCK;
         lock_s_q    <= lock_meta_q;
         state_q     <= state_d;
         deb_q       <= deb_d;
         stg_q       <= stg_d;
         idx_q       <= idx_d;
         rst_q       <= rst_d;
         ready_q     <= ready_d;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      fccc_ce_div #(
         .DIV_W (DIV_W)
      ) u_div (
         .clk      (CLK),
         .reset    (RESET),
         .rst_cur  (rst_q[k]),
         .rst_nxt  (rst_d[k]),
         .ratio_in (DIV_RATIO[k*DIV_W +: DIV_W]),
         .ce_out   (CE_OUT[k])
      );
   end

`ifdef FCCC_LOCK_LOSS_CNT_EN
   logic [7:0] lost_cnt_q, lost_cnt_d;

   always_comb begin
      lost_cnt_d = lost_cnt_q;
      if ((state_d == ST_LOST) && (state_q != ST_LOST)) begin
         lost_cnt_d = sat_inc8(lost_cnt_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lost_cnt_q <= '0;
      end else begin
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign LOCK_LOST_CNT = lost_cnt_q;
`else
   assign LOCK_LOST_CNT = 8'd0;
`endif

   assign RST_OUT = rst_q;
   assign READY   = ready_q;

endmodule

// File: tb/tb_fccc_rst_seq.sv
// Scoreboard bench for fccc_rst_seq: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_fccc_rst_seq;

   localparam int SEL_RST = 0;
   localparam int SEL_CE  = 1;
   localparam int SEL_RDY = 2;
   localparam int SEL_CNT = 3;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        LOCK;
   logic [31:0] DIV_RATIO;
   logic [3:0]  CE_OUT;
   logic [3:0]  RST_OUT;
   logic        READY;
   logic [7:0]  LOCK_LOST_CNT;

   fccc_rst_seq #(
      .NUM_CH        (4),
      .DIV_W         (8),
      .LOCK_DEBOUNCE (16),
      .STAGGER       (4)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .LOCK          (LOCK),
      .DIV_RATIO     (DIV_RATIO),
      .CE_OUT        (CE_OUT),
      .RST_OUT       (RST_OUT),
      .READY         (READY),
      .LOCK_LOST_CNT (LOCK_LOST_CNT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc = cyc + 1;

   int          q_cyc[$];
   int          q_sel[$];
   logic [31:0] q_val[$];
   string       q_nm[$];

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mon_act;

   int t_n, t_m, t_p, t_q, t_r, t_s;

   task automatic expect_at(input int at, input int sel, input logic [31:0] val, input string nm);
      q_cyc.push_back(at);
      q_sel.push_back(sel);
      q_val.push_back(val);
      q_nm.push_back(nm);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         SEL_RST: return {28'd0, RST_OUT};
         SEL_CE:  return {28'd0, CE_OUT};
         SEL_RDY: return {31'd0, READY};
         default: return {24'd0, LOCK_LOST_CNT};
      endcase
   endfunction

   function automatic logic [31:0] exp_cnt(input int events);
`ifdef FCCC_LOCK_LOSS_CNT_EN
      return (events > 255) ? 32'd255 : 32'(events);
`else
      return (events >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   always @(negedge CLK) begin
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
         if (q_cyc[i] <= cyc) begin
            n_cmp++;
            if (q_cyc[i] < cyc) begin
               n_err++;
               $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", q_nm[i], q_cyc[i], cyc);
            end else begin
               mon_act = pick(q_sel[i]);
               if (mon_act !== q_val[i]) begin
                  n_err++;
                  $display("FAIL %s @cycle %0d: got 0x%0h required 0x%0h", q_nm[i], cyc, mon_act, q_val[i]);
               end
            end
            q_cyc.delete(i);
            q_sel.delete(i);
            q_val.delete(i);
            q_nm.delete(i);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      RESET     = 1'b1;
      LOCK      = 1'b0;
      DIV_RATIO = {8'd255, 8'd3, 8'd1, 8'd0};
      repeat (3) step();
      expect_at(cyc, SEL_RST, 32'hF, "reset_rst");
      expect_at(cyc, SEL_CE,  32'h0, "reset_ce");
      expect_at(cyc, SEL_RDY, 32'h0, "reset_ready");
      expect_at(cyc, SEL_CNT, 32'h0, "reset_cnt");
      RESET = 1'b0;
      step();
      step();

      // staggered release and divider pattern
      t_n  = cyc;
      LOCK = 1'b1;
      expect_at(t_n + 18, SEL_RST, 32'hF, "rel_not_early");
      expect_at(t_n + 19, SEL_RST, 32'hE, "rel_ch0");
      expect_at(t_n + 22, SEL_RST, 32'hE, "rel_ch1_wait");
      expect_at(t_n + 23, SEL_RST, 32'hC, "rel_ch1");
      expect_at(t_n + 26, SEL_RST, 32'hC, "rel_ch2_wait");
      expect_at(t_n + 27, SEL_RST, 32'h8, "rel_ch2");
      expect_at(t_n + 30, SEL_RST, 32'h8, "rel_ch3_wait");
      expect_at(t_n + 31, SEL_RST, 32'h0, "rel_ch3");
      expect_at(t_n + 31, SEL_RDY, 32'h0, "ready_wait");
      expect_at(t_n + 32, SEL_RDY, 32'h1, "ready_rise");
      expect_at(t_n + 19, SEL_CE, 32'h0, "ce_at_rel0");
      expect_at(t_n + 20, SEL_CE, 32'h1, "ce_ratio0_first");
      expect_at(t_n + 25, SEL_CE, 32'h3, "ce_ch1_first");
      expect_at(t_n + 26, SEL_CE, 32'h1, "ce_ch1_low");
      expect_at(t_n + 31, SEL_CE, 32'h7, "ce_ch2_first");
      expect_at(t_n + 32, SEL_CE, 32'h1, "ce_n32");
      expect_at(t_n + 33, SEL_CE, 32'h3, "ce_n33");
      expect_at(t_n + 35, SEL_CE, 32'h7, "ce_ch2_second");
      expect_at(t_n + 37, SEL_CE, 32'h3, "ce_midchg_keep");
      expect_at(t_n + 38, SEL_CE, 32'h1, "ce_n38");
      expect_at(t_n + 39, SEL_CE, 32'h7, "ce_pending_pulse");
      expect_at(t_n + 40, SEL_CE, 32'h1, "ce_n40");
      expect_at(t_n + 41, SEL_CE, 32'h7, "ce_new_ratio");
      expect_at(t_n + 286, SEL_CE, 32'h1, "ce_ch3_before");
      expect_at(t_n + 287, SEL_CE, 32'hF, "ce_ch3_first");
      expect_at(t_n + 288, SEL_CE, 32'h1, "ce_ch3_after");
      expect_at(t_n + 542, SEL_CE, 32'h1, "ce_ch3_before2");
      expect_at(t_n + 543, SEL_CE, 32'hF, "ce_ch3_second");
      expect_at(t_n + 540, SEL_RDY, 32'h1, "ready_hold");
      wait_until(t_n + 36);
      DIV_RATIO = {8'd255, 8'd1, 8'd1, 8'd0};
      wait_until(t_n + 545);

      // lock loss while running
      t_m  = cyc;
      LOCK = 1'b0;
      expect_at(t_m + 2, SEL_RST, 32'h0, "lost_before_rst");
      expect_at(t_m + 2, SEL_RDY, 32'h1, "lost_before_rdy");
      expect_at(t_m + 3, SEL_RST, 32'hF, "lost_rst");
      expect_at(t_m + 3, SEL_CE,  32'h0, "lost_ce");
      expect_at(t_m + 3, SEL_RDY, 32'h0, "lost_rdy");
      expect_at(t_m + 3, SEL_CNT, exp_cnt(1), "lost_cnt_1");
      expect_at(t_m + 5, SEL_RST, 32'hF, "lost_idle_rst");
      wait_until(t_m + 6);

      // short lock pulse must not release
      t_p  = cyc;
      LOCK = 1'b1;
      expect_at(t_p + 12, SEL_RST, 32'hF, "short_rst_a");
      expect_at(t_p + 19, SEL_RST, 32'hF, "short_rst_b");
      expect_at(t_p + 25, SEL_RST, 32'hF, "short_rst_c");
      expect_at(t_p + 25, SEL_RDY, 32'h0, "short_rdy");
      wait_until(t_p + 10);
      LOCK = 1'b0;
      wait_until(t_p + 30);

      // clean lock restarts full debounce; RESET mid-release
      t_q  = cyc;
      LOCK = 1'b1;
      expect_at(t_q + 18, SEL_RST, 32'hF, "relock_not_early");
      expect_at(t_q + 19, SEL_RST, 32'hE, "relock_ch0");
      expect_at(t_q + 23, SEL_RST, 32'hC, "relock_ch1");
      expect_at(t_q + 25, SEL_RST, 32'hC, "prereset_rst");
      expect_at(t_q + 26, SEL_RST, 32'hF, "reset_mid_rst");
      expect_at(t_q + 26, SEL_CE,  32'h0, "reset_mid_ce");
      expect_at(t_q + 26, SEL_RDY, 32'h0, "reset_mid_rdy");
      expect_at(t_q + 26, SEL_CNT, 32'h0, "reset_mid_cnt");
      expect_at(t_q + 28, SEL_RST, 32'hF, "reset_hold_rst");
      wait_until(t_q + 25);
      RESET = 1'b1;
      wait_until(t_q + 28);
      RESET = 1'b0;
      t_r = cyc;
      expect_at(t_r + 18, SEL_RST, 32'hF, "postrst_not_early");
      expect_at(t_r + 19, SEL_RST, 32'hE, "postrst_ch0");
      expect_at(t_r + 31, SEL_RST, 32'h0, "postrst_all");
      expect_at(t_r + 31, SEL_RDY, 32'h0, "postrst_rdy_wait");
      expect_at(t_r + 32, SEL_RDY, 32'h1, "postrst_rdy");
      wait_until(t_r + 33);

      // repeated lock loss: saturation (or constant 0 without the counter)
      LOCK = 1'b0;
      expect_at(t_r + 36, SEL_CNT, exp_cnt(1), "loss_cnt_first");
      wait_until(t_r + 40);
      for (int i = 2; i <= 300; i++) begin
         t_s  = cyc;
         LOCK = 1'b1;
         expect_at(t_s + 19, SEL_RST, 32'hE, "loop_rel_ch0");
         expect_at(t_s + 22, SEL_CNT, exp_cnt(i - 1), "loop_cnt_hold");
         expect_at(t_s + 23, SEL_CNT, exp_cnt(i), "loop_cnt_inc");
         expect_at(t_s + 23, SEL_RST, 32'hF, "loop_lost_rst");
         wait_until(t_s + 20);
         LOCK = 1'b0;
         wait_until(t_s + 26);
      end
      expect_at(cyc + 3, SEL_CNT, exp_cnt(300), "loss_cnt_final");
      expect_at(cyc + 3, SEL_RDY, 32'h0, "final_rdy");
      wait_until(cyc + 6);

      n_cmp++;
      if (q_cyc.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q_cyc.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
